// File: rtl/counter_rr_scheduler.sv
// Round-robin scheduler sharing one external 2-bit counter among NREQ requesters.
// Each grant clears the counter, runs a QUANTUM-cycle slice, then returns the count tagged with the owner.
module counter_rr_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned QUANTUM = 4
) (
  input  logic                    clk_i,
  input  logic                    nreset_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ-1:0]         req_in_i,
  input  logic [1:0]              count_i,
  output logic [NREQ-1:0]         grant_o,
  output logic                    busy_o,
  output logic                    cnt_in_o,
  output logic                    cnt_clr_o,
  output logic                    done_o,
  output logic [1:0]              result_o,
  output logic [$clog2(NREQ)-1:0] result_id_o,
  output logic                    result_abort_o
);

  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    CAPTURE
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [7:0]      slice_q, slice_d;
  logic            abort_q, abort_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            cnt_clr_q, cnt_clr_d;
  logic            done_q, done_d;
  logic [1:0]      result_q, result_d;
  logic [IDW-1:0]  result_id_q, result_id_d;
  logic            result_abort_q, result_abort_d;

  logic            pick_found;
  logic [IDW-1:0]  pick_idx;
  logic [IDW-1:0]  cand;

  // Scan from ptr+1 upward with wrap; the first set request wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IDW'((32'(ptr_q) + i) % NREQ);
      if (!pick_found && req_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    ptr_d          = ptr_q;
    slice_d        = slice_q;
    abort_d        = abort_q;
    grant_d        = grant_q;
    done_d         = 1'b0;
    result_d       = result_q;
    result_id_d    = result_id_q;
    result_abort_d = result_abort_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d           = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          abort_d           = 1'b0;
          state_d           = CLEAR;
        end
      end
      CLEAR: begin
        slice_d = 8'(QUANTUM - 1);
        state_d = RUN;
      end
      RUN: begin
        if (!req_i[owner_q]) begin
          abort_d = 1'b1;
          state_d = CAPTURE;
        end else if (slice_q == '0) begin
          state_d = CAPTURE;
        end else begin
          slice_d = slice_q - 8'd1;
        end
      end
      CAPTURE: begin
        result_d       = count_i;
        result_id_d    = owner_q;
        result_abort_d = abort_q;
        done_d         = 1'b1;
        ptr_d          = owner_q;
        grant_d        = '0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registered so the counter clear is glitch-free and low exactly during CLEAR.
    cnt_clr_d = (state_d != CLEAR);
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q        <= IDLE;
      owner_q        <= '0;
      ptr_q          <= IDW'(NREQ - 1);
      slice_q        <= '0;
      abort_q        <= 1'b0;
      grant_q        <= '0;
      cnt_clr_q      <= 1'b0;
      done_q         <= 1'b0;
      result_q       <= '0;
      result_id_q    <= '0;
      result_abort_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      ptr_q          <= ptr_d;
      slice_q        <= slice_d;
      abort_q        <= abort_d;
      grant_q        <= grant_d;
      cnt_clr_q      <= cnt_clr_d;
      done_q         <= done_d;
      result_q       <= result_d;
      result_id_q    <= result_id_d;
      result_abort_q <= result_abort_d;
    end
  end

  assign grant_o        = grant_q;
  assign busy_o         = (state_q != IDLE);
  assign cnt_in_o       = (state_q == RUN) && req_in_i[owner_q] && req_i[owner_q];
  assign cnt_clr_o      = cnt_clr_q;
  assign done_o         = done_q;
  assign result_o       = result_q;
  assign result_id_o    = result_id_q;
  assign result_abort_o = result_abort_q;

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Bench for counter_rr_scheduler: slice-level reference model plus directed scenarios and random traffic.
module tb_counter_rr_scheduler;
  localparam int NREQ = 4;
  localparam int Q    = 4;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] req_in = '0;
  logic [1:0] cnt = '0;
  logic [3:0] grant;
  logic       busy, cnt_in, cnt_clr, done, rab;
  logic [1:0] res, rid;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  counter_rr_scheduler #(.NREQ(NREQ), .QUANTUM(Q)) dut (
    .clk_i(clk), .nreset_i(nrst), .req_i(req), .req_in_i(req_in), .count_i(cnt),
    .grant_o(grant), .busy_o(busy), .cnt_in_o(cnt_in), .cnt_clr_o(cnt_clr),
    .done_o(done), .result_o(res), .result_id_o(rid), .result_abort_o(rab)
  );

  // The shared external counter the scheduler drives.
  always @(posedge clk or negedge cnt_clr) begin
    if (!cnt_clr) cnt <= '0;
    else if (cnt_in) cnt <= cnt + 2'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Slice-level model: owner, position within slice (0 = clear, 1..Q = run), running tally.
  bit m_busy = 0, m_cap = 0, m_ab = 0, m_clr = 0, m_done = 0, m_rab = 0;
  int m_own = 0, m_pos = 0, m_tally = 0, m_ptr = NREQ - 1, m_res = 0, m_rid = 0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_busy = 0; m_cap = 0; m_clr = 0; m_done = 0;
      m_ptr = NREQ - 1; m_res = 0; m_rid = 0; m_rab = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (!m_busy && req[(m_ptr + k) % NREQ]) begin
            m_busy = 1; m_own = (m_ptr + k) % NREQ;
            m_pos = 0; m_tally = 0; m_ab = 0; m_cap = 0;
          end
        end
      end else if (m_cap) begin
        m_res = m_tally % 4; m_rid = m_own; m_rab = m_ab;
        m_done = 1; m_ptr = m_own; m_busy = 0; m_cap = 0;
      end else if (m_pos == 0) begin
        m_pos = 1;
      end else begin
        if (!req[m_own]) begin
          m_ab = 1; m_cap = 1;
        end else begin
          if (req_in[m_own]) m_tally++;
          if (m_pos == Q) m_cap = 1;
          else m_pos++;
        end
      end
      m_clr = !(m_busy && !m_cap && m_pos == 0);
    end
  end

  logic [3:0] e_grant;
  logic       e_cin;
  always @(negedge clk) begin
    e_grant = m_busy ? 4'(1 << m_own) : 4'b0;
    e_cin   = m_busy && !m_cap && (m_pos >= 1) && req[m_own] && req_in[m_own];
    chk("grant", grant, e_grant);
    chk("grant_onehot", $onehot0(grant), 1);
    chk("busy", busy, m_busy);
    chk("cnt_in", cnt_in, e_cin);
    chk("cnt_clr", cnt_clr, m_clr);
    chk("done", done, m_done);
    chk("result", res, m_res);
    chk("result_id", rid, m_rid);
    chk("result_abort", rab, m_rab);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    nrst = 0; req = '0; req_in = '0;
    tick(); tick();
    nrst = 1;
    tick();
    chk("clr_after_release", cnt_clr, 1);
  endtask

  task automatic wait_done(input int e0, input int lat, input int eres, input int eid,
                           input int eab, input string tag);
    int n = 0;
    do begin tick(); n++; end while (!done && n < 40);
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL %s_timeout: got no done_o expected done_o within 40 cycles", tag);
    end else begin
      if (lat >= 0)  chk({tag, "_latency"}, cyc - e0, lat);
      if (eres >= 0) chk({tag, "_result"}, res, eres);
      if (eid >= 0)  chk({tag, "_id"}, rid, eid);
      if (eab >= 0)  chk({tag, "_abort"}, rab, eab);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish before 1ms");
    $fatal(1);
  end

  int e0;
  int bit_idx;
  initial begin
    #1 nrst = 0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt_clr", cnt_clr, 0);
    chk("rst_cnt_in", cnt_in, 0);
    chk("rst_done", done, 0);
    chk("rst_result", {rab, rid, res}, 0);
    tick(); tick();
    nrst = 1;
    tick();
    chk("clr_after_release", cnt_clr, 1);

    // Pattern 1,0,1,1 on requester 0.
    req = 4'b0001; req_in = '0;
    tick(); e0 = cyc;
    tick(); req_in = 4'b0001;
    tick(); req_in = 4'b0000;
    tick(); req_in = 4'b0001;
    tick();
    tick(); req_in = 4'b0000;
    wait_done(e0, Q + 2, 3, 0, 0, "s1");
    req = '0;
    tick(); tick();

    // Constant count wraps 3 -> 0; held request re-granted after one idle bubble.
    req = 4'b0001; req_in = 4'b0001;
    tick(); e0 = cyc;
    wait_done(e0, Q + 2, 0, 0, 0, "s2");
    chk("s2_bubble_busy", busy, 0);
    tick();
    chk("s2_regrant", grant, 4'b0001);
    req = '0;
    wait_done(-1, -1, 0, 0, 1, "s2b");
    tick();

    // All requesting: strict rotation.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      req_in = 4'($urandom);
      wait_done(-1, -1, -1, i % 4, 0, "s3");
    end
    req = '0;
    tick(); tick();

    // After requester 2, requester 3 precedes requester 0.
    do_reset();
    req = 4'b0100; req_in = 4'b0100;
    wait_done(-1, -1, 0, 2, 0, "s4a");
    req = 4'b1001;
    wait_done(-1, -1, -1, 3, 0, "s4b");
    wait_done(-1, -1, -1, 0, 0, "s4c");
    req = '0;
    tick(); tick();

    // Owner 1 drops its request in RUN cycle 2.
    do_reset();
    req = 4'b0010; req_in = 4'b0010;
    tick(); e0 = cyc;
    tick();
    tick(); req = 4'b0000;
    wait_done(e0, 4, 1, 1, 1, "s5");
    tick();

    // Asynchronous reset in RUN cycle 3.
    req = 4'b0001; req_in = 4'b0001;
    tick(); e0 = cyc;
    tick(); tick(); tick();
    #1 nrst = 0;
    #1;
    chk("s6_async_grant", grant, 0);
    chk("s6_async_busy", busy, 0);
    chk("s6_async_clr", cnt_clr, 0);
    req = 4'b0011;
    tick();
    chk("s6_no_done", done, 0);
    nrst = 1;
    tick();
    chk("s6_first_grant", grant, 4'b0001);
    wait_done(-1, -1, -1, 0, 0, "s6");
    req = '0;
    tick(); tick();

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bit_idx = $urandom_range(0, 3);
        req[bit_idx] = ~req[bit_idx];
      end
      req_in = 4'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        nrst = 0;
        tick();
        nrst = 1;
      end
      tick();
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
